// File: rtl/data_mem_port_if.sv
// data_mem_port_if: store/load bus between the memory-write pipeline stage and
// the data-memory responder.
//   master: drives store requests (write_mem/addr_mem/wdata_mem) and load requests
//           (rd_req/rd_addr); observes rd_valid/rd_data, stall, sb_count, sb_empty.
//   slave : the responder; the reverse directions.
interface data_mem_port_if #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SB_DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  logic              write_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0] wdata_mem;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              stall;
  logic [CNT_W-1:0]  sb_count;
  logic              sb_empty;

  modport master (
    output write_mem, addr_mem, wdata_mem, rd_req, rd_addr,
    input  rd_valid, rd_data, stall, sb_count, sb_empty
  );

  modport slave (
    input  write_mem, addr_mem, wdata_mem, rd_req, rd_addr,
    output rd_valid, rd_data, stall, sb_count, sb_empty
  );
endinterface

// File: rtl/data_mem_port.sv
// data_mem_port: data-memory responder. Stores enter an in-order store buffer
// and drain into a single-port 2^ADDR_W x DATA_W synchronous RAM. Loads return
// one cycle after rd_req, forwarded from the youngest matching pending store
// when there is one, otherwise read from the RAM.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : data_mem_port_if.slave (store, load, stall and occupancy signals)
module data_mem_port #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SB_DEPTH = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  data_mem_port_if.slave bus
);
  localparam int unsigned PTR_W     = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  // Store buffer state
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] r_sb_data [SB_DEPTH];

  // RAM and read-return state
  logic [DATA_W-1:0] r_mem [RAM_DEPTH];
  logic [DATA_W-1:0] r_ram_rdata;
  logic [DATA_W-1:0] r_fwd_rdata;
  logic              r_rd_src_ram;
  logic              r_rd_valid;

  logic              w_stall;
  logic              w_push;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_ram_rd;
  logic              w_fwd_rd;
  logic              w_drain;
  logic              w_ram_we;

  assign w_stall = (r_count == CNT_W'(SB_DEPTH));
  assign w_push  = bus.write_mem && !w_stall;

  // Youngest match wins: scan oldest to youngest so later hits overwrite,
  // then let the incoming store override everything.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_sb_addr[idx] == bus.rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_sb_data[idx];
      end
    end
    if (w_push && (bus.addr_mem == bus.rd_addr)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = bus.wdata_mem;
    end
  end

  // One RAM access per cycle: a RAM read beats a drain.
  assign w_ram_rd = bus.rd_req && !w_fwd_hit;
  assign w_fwd_rd = bus.rd_req && w_fwd_hit;
  assign w_drain  = !w_ram_rd && (r_count != '0);
  // Keeps a drain from landing in the RAM on an edge that coincides with reset.
  assign w_ram_we = w_drain && i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + PTR_W'(1);
      if (w_drain) r_head <= r_head + PTR_W'(1);
      unique case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset; validity comes from head/count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_sb_addr[r_tail] <= bus.addr_mem;
      r_sb_data[r_tail] <= bus.wdata_mem;
    end
  end

  // Single-port synchronous RAM, contents not reset.
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[r_sb_addr[r_head]] <= r_sb_data[r_head];
    end
    if (w_ram_rd) begin
      r_ram_rdata <= r_mem[bus.rd_addr];
    end
  end

  // Return path: remember which source answered so rd_data holds its last
  // value while no read is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid   <= 1'b0;
      r_rd_src_ram <= 1'b0;
      r_fwd_rdata  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) r_rd_src_ram <= w_ram_rd;
      if (w_fwd_rd)   r_fwd_rdata  <= w_fwd_data;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_src_ram ? r_ram_rdata : r_fwd_rdata;
  assign bus.stall    = w_stall;
  assign bus.sb_count = r_count;
  assign bus.sb_empty = (r_count == '0);
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: reset, store/load forwarding, back-pressure,
// pointer wrap-around and RAM readback.
module tb_data_mem_port;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SB_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  data_mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) u_if ();

  data_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (u_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_store(input logic we, input logic [8:0] a, input logic [15:0] d);
    u_if.write_mem = we;
    u_if.addr_mem  = a;
    u_if.wdata_mem = d;
  endtask

  task automatic set_read(input logic req, input logic [8:0] a);
    u_if.rd_req  = req;
    u_if.rd_addr = a;
  endtask

  initial begin
    set_store(1'b0, 9'h0, 16'h0);
    set_read(1'b0, 9'h0);
    tick();
    tick();
    // Reset state
    check("rst_count", 32'(u_if.sb_count), 32'd0);
    check("rst_empty", 32'(u_if.sb_empty), 32'd1);
    check("rst_stall", 32'(u_if.stall), 32'd0);
    check("rst_valid", 32'(u_if.rd_valid), 32'd0);
    check("rst_data", 32'(u_if.rd_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: preload RAM 0x010..0x012, then buffer overwrites and reset mid-run
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 9'(9'h010 + i), 16'(16'h5550 + i));
      tick();
    end
    set_store(1'b0, 9'h0, 16'h0);
    tick();
    tick();
    tick();
    check("t1_preload_empty", 32'(u_if.sb_empty), 32'd1);
    set_read(1'b1, 9'h1FF);
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 9'(9'h010 + i), 16'(16'hA010 + i));
      tick();
    end
    set_store(1'b0, 9'h0, 16'h0);
    check("t1_buffered", 32'(u_if.sb_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_count", 32'(u_if.sb_count), 32'd0);
    check("t1_rst_empty", 32'(u_if.sb_empty), 32'd1);
    check("t1_rst_valid", 32'(u_if.rd_valid), 32'd0);
    check("t1_rst_stall", 32'(u_if.stall), 32'd0);
    set_read(1'b0, 9'h0);
    tick();
    rst_n = 1'b1;
    tick();
    set_read(1'b1, 9'h010);
    tick();
    check("t1_ram010_valid", 32'(u_if.rd_valid), 32'd1);
    check("t1_ram010", 32'(u_if.rd_data), 32'h5550);
    set_read(1'b1, 9'h012);
    tick();
    check("t1_ram012", 32'(u_if.rd_data), 32'h5552);
    set_read(1'b0, 9'h0);
    tick();

    // 2: store, idle, read from RAM
    set_store(1'b1, 9'h005, 16'h1234);
    tick();
    set_store(1'b0, 9'h0, 16'h0);
    tick();
    tick();
    check("t2_empty", 32'(u_if.sb_empty), 32'd1);
    set_read(1'b1, 9'h005);
    tick();
    check("t2_valid", 32'(u_if.rd_valid), 32'd1);
    check("t2_data", 32'(u_if.rd_data), 32'h1234);
    set_read(1'b0, 9'h0);
    tick();
    check("t2_valid_low", 32'(u_if.rd_valid), 32'd0);
    check("t2_data_hold", 32'(u_if.rd_data), 32'h1234);

    // 3: same-cycle store+read with an older buffered store to same address
    set_read(1'b1, 9'h1FF);
    set_store(1'b1, 9'h020, 16'h1111);
    tick();
    check("t3_older_buffered", 32'(u_if.sb_count), 32'd1);
    set_store(1'b1, 9'h020, 16'hBEEF);
    set_read(1'b1, 9'h020);
    tick();
    check("t3_fwd_valid", 32'(u_if.rd_valid), 32'd1);
    check("t3_fwd_data", 32'(u_if.rd_data), 32'hBEEF);
    set_store(1'b0, 9'h0, 16'h0);
    set_read(1'b0, 9'h0);
    tick();
    tick();
    check("t3_drained", 32'(u_if.sb_empty), 32'd1);
    set_read(1'b1, 9'h020);
    tick();
    check("t3_ram020", 32'(u_if.rd_data), 32'hBEEF);

    // 4: fill under continuous RAM reads, 5th store stalled, then drain
    set_read(1'b1, 9'h1FE);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 9'(9'h030 + i), 16'(16'hC000 + i));
      tick();
    end
    check("t4_full_count", 32'(u_if.sb_count), 32'd4);
    check("t4_stall", 32'(u_if.stall), 32'd1);
    set_store(1'b1, 9'h034, 16'hC004);
    tick();
    check("t4_ignored", 32'(u_if.sb_count), 32'd4);
    check("t4_rd_valid", 32'(u_if.rd_valid), 32'd1);
    set_read(1'b0, 9'h0);
    tick();
    check("t4_first_drain", 32'(u_if.sb_count), 32'd3);
    check("t4_stall_fell", 32'(u_if.stall), 32'd0);
    tick();
    check("t4_accept5", 32'(u_if.sb_count), 32'd3);
    set_store(1'b0, 9'h0, 16'h0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("t4_drain_step", 32'(u_if.sb_count), 32'(i));
    end
    set_read(1'b1, 9'h034);
    tick();
    check("t4_ram034", 32'(u_if.rd_data), 32'hC004);
    set_read(1'b1, 9'h030);
    tick();
    check("t4_ram030", 32'(u_if.rd_data), 32'hC000);
    set_read(1'b0, 9'h0);
    tick();

    // 5: wrap-around with interleaved forwarded and RAM reads
    for (int i = 0; i < 10; i++) begin
      set_store(1'b1, 9'(9'h100 + i), 16'(16'h0100 + i));
      set_read(1'b1, (i % 4 == 3) ? 9'h1FD : 9'(9'h100 + i));
      tick();
      check("t5_valid", 32'(u_if.rd_valid), 32'd1);
      if (i % 4 != 3) check("t5_fwd", 32'(u_if.rd_data), 32'(16'h0100 + i));
    end
    set_store(1'b0, 9'h0, 16'h0);
    set_read(1'b0, 9'h0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_empty", 32'(u_if.sb_empty), 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_read(1'b1, 9'(9'h100 + i));
      tick();
      check("t5_readback", 32'(u_if.rd_data), 32'(16'h0100 + i));
    end
    set_read(1'b0, 9'h0);
    tick();

    // 6: never-written read, and forwarding over an unwritten RAM location
    set_read(1'b1, 9'h1F0);
    tick();
    check("t6_unwritten_valid", 32'(u_if.rd_valid), 32'd1);
    set_read(1'b1, 9'h1FC);
    set_store(1'b1, 9'h040, 16'h7777);
    tick();
    set_store(1'b0, 9'h0, 16'h0);
    set_read(1'b1, 9'h040);
    tick();
    check("t6_fwd_buffer", 32'(u_if.rd_data), 32'h7777);
    set_read(1'b0, 9'h0);
    tick();
    check("t6_empty", 32'(u_if.sb_empty), 32'd1);
    set_read(1'b1, 9'h040);
    tick();
    check("t6_ram040", 32'(u_if.rd_data), 32'h7777);
    set_read(1'b0, 9'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
